// File: rtl/regfile_port_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// regarb_pkg
// Shared definitions for the register-file port arbiter/sequencer:
//   - default data/address widths
//   - operation encodings carried on op0/op1
//   - sequencer state enumeration
//   - number of register-file steps each operation takes
// ---------------------------------------------------------------------------
package regarb_pkg;

    localparam int DW_DEF = 8;
    localparam int AW_DEF = 4;

    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_MOVE  = 2'b10;
    localparam logic [1:0] OP_SWAP  = 2'b11;

    // Register-file accesses per operation (ACK and IDLE not included).
    localparam int unsigned STEPS_READ  = 1;
    localparam int unsigned STEPS_WRITE = 1;
    localparam int unsigned STEPS_MOVE  = 2;
    localparam int unsigned STEPS_SWAP  = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_A,
        ST_RD_B,
        ST_WR_A,
        ST_WR_B,
        ST_ACK
    } state_t;

    function automatic int unsigned op_steps(input logic [1:0] op);
        case (op)
            OP_READ:  return STEPS_READ;
            OP_WRITE: return STEPS_WRITE;
            OP_MOVE:  return STEPS_MOVE;
            default:  return STEPS_SWAP;
        endcase
    endfunction

endpackage

// File: rtl/regfile_port_arbiter_rr_pick2.sv
// ---------------------------------------------------------------------------
// rr_pick2
// Combinational two-way round-robin picker. The pointer register lives in
// the parent; this block only decides the winner and the next pointer.
// Ports:
//   req[1:0]     in  : request bits, bit n from requester n
//   ptr          in  : requester favoured when both request
//   en           in  : picking allowed this cycle
//   grant_id     out : winning requester (meaningful when grant_valid)
//   grant_valid  out : a grant is issued this cycle
//   ptr_next     out : pointer value after this cycle (moves to the loser)
// ---------------------------------------------------------------------------
module rr_pick2 (
    input  logic [1:0] req,
    input  logic       ptr,
    input  logic       en,
    output logic       grant_id,
    output logic       grant_valid,
    output logic       ptr_next
);

    always_comb begin
        grant_valid = en & (|req);
        if (req[0] && req[1]) begin
            grant_id = ptr;
        end else begin
            grant_id = req[1];
        end
        ptr_next = grant_valid ? ~grant_id : ptr;
    end

endmodule

// File: rtl/regfile_port_arbiter.sv
// ---------------------------------------------------------------------------
// regfile_port_arbiter
// Shares the single port of the CPU register file between the core path
// (requester 0) and the debug/load path (requester 1), and sequences the
// multi-access MOVE and SWAP operations.
// Ports:
//   clk, rst                  : clock, synchronous active-high reset
//   req0/req1                 : command requests
//   op0/op1                   : 00 READ, 01 WRITE, 10 MOVE, 11 SWAP
//   addra0/addra1             : register A
//   addrb0/addrb1             : register B (MOVE/SWAP only)
//   wdata0/wdata1             : write data (WRITE only)
//   ack0/ack1                 : one-cycle completion pulse
//   rdata                     : operation result, valid with ack, held after
//   rf_write/rf_read          : register-file strobes
//   rf_addr/rf_in             : register-file address / write data
//   rf_data                   : register-file read data (combinational)
// ---------------------------------------------------------------------------
module regfile_port_arbiter
    import regarb_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int AW = AW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0,
    input  logic          req1,
    input  logic [1:0]    op0,
    input  logic [1:0]    op1,
    input  logic [AW-1:0] addra0,
    input  logic [AW-1:0] addra1,
    input  logic [AW-1:0] addrb0,
    input  logic [AW-1:0] addrb1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    output logic          ack0,
    output logic          ack1,
    output logic [DW-1:0] rdata,
    output logic          rf_write,
    output logic          rf_read,
    output logic [AW-1:0] rf_addr,
    output logic [DW-1:0] rf_in,
    input  logic [DW-1:0] rf_data
);

    state_t        r_state;
    state_t        w_state_next;
    logic          r_ptr;
    logic          r_id;
    logic [1:0]    r_op;
    logic [AW-1:0] r_addra;
    logic [AW-1:0] r_addrb;
    logic [DW-1:0] r_wdata;
    logic [DW-1:0] r_tmp_a;
    logic [DW-1:0] r_tmp_b;
    logic [DW-1:0] r_rdata;

    logic          w_idle;
    logic          w_grant_id;
    logic          w_grant_valid;
    logic          w_ptr_next;
    logic [1:0]    w_win_op;
    logic [DW-1:0] w_result;
    logic          w_load_rdata;

    assign w_idle = (r_state == ST_IDLE);

    rr_pick2 u_pick (
        .req         ({req1, req0}),
        .ptr         (r_ptr),
        .en          (w_idle),
        .grant_id    (w_grant_id),
        .grant_valid (w_grant_valid),
        .ptr_next    (w_ptr_next)
    );

    assign w_win_op = w_grant_id ? op1 : op0;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_grant_valid) begin
                    w_state_next = (w_win_op == OP_WRITE) ? ST_WR_A : ST_RD_A;
                end
            end
            ST_RD_A: begin
                case (r_op)
                    OP_READ: w_state_next = ST_ACK;
                    OP_MOVE: w_state_next = ST_WR_B;
                    default: w_state_next = ST_RD_B;
                endcase
            end
            ST_RD_B: w_state_next = ST_WR_A;
            ST_WR_A: w_state_next = (r_op == OP_SWAP) ? ST_WR_B : ST_ACK;
            ST_WR_B: w_state_next = ST_ACK;
            ST_ACK:  w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Result is loaded on the edge into ACK. A READ finishes in RD_A, before
    // tmp_a is written, so it takes rf_data directly.
    always_comb begin
        case (r_op)
            OP_READ:  w_result = rf_data;
            OP_WRITE: w_result = r_wdata;
            default:  w_result = r_tmp_a;
        endcase
        w_load_rdata = (w_state_next == ST_ACK) && (r_state != ST_ACK);
    end

    always_comb begin
        rf_read  = 1'b0;
        rf_write = 1'b0;
        rf_addr  = '0;
        rf_in    = '0;
        if (!rst) begin
            case (r_state)
                ST_RD_A: begin
                    rf_read = 1'b1;
                    rf_addr = r_addra;
                end
                ST_RD_B: begin
                    rf_read = 1'b1;
                    rf_addr = r_addrb;
                end
                ST_WR_A: begin
                    rf_write = 1'b1;
                    rf_addr  = r_addra;
                    rf_in    = (r_op == OP_WRITE) ? r_wdata : r_tmp_b;
                end
                ST_WR_B: begin
                    rf_write = 1'b1;
                    rf_addr  = r_addrb;
                    rf_in    = r_tmp_a;
                end
                default: ;
            endcase
        end
    end

    assign ack0  = (r_state == ST_ACK) && !r_id;
    assign ack1  = (r_state == ST_ACK) &&  r_id;
    assign rdata = r_rdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_ptr   <= 1'b0;
            r_id    <= 1'b0;
            r_op    <= OP_READ;
            r_addra <= '0;
            r_addrb <= '0;
            r_wdata <= '0;
            r_tmp_a <= '0;
            r_tmp_b <= '0;
            r_rdata <= '0;
        end else begin
            r_state <= w_state_next;
            r_ptr   <= w_ptr_next;
            if (w_grant_valid) begin
                r_id    <= w_grant_id;
                r_op    <= w_win_op;
                r_addra <= w_grant_id ? addra1 : addra0;
                r_addrb <= w_grant_id ? addrb1 : addrb0;
                r_wdata <= w_grant_id ? wdata1 : wdata0;
            end
            if (r_state == ST_RD_A) begin
                r_tmp_a <= rf_data;
            end
            if (r_state == ST_RD_B) begin
                r_tmp_b <= rf_data;
            end
            if (w_load_rdata) begin
                r_rdata <= w_result;
            end
        end
    end

endmodule
